demux_1_2_4b: RTL and testbench
===============================

# demux_1_2_4b

Receive-side counterpart of the 2:1 4-bit nibble multiplexer. It takes a 4-bit bus carrying alternating low/high nibbles, tagged by `sel`, and demultiplexes them back into two registered nibbles. The two nibbles are presented as one assembled byte over a valid/ready handshake. It sits at the far end of a nibble link driven by the mux, with sequence checking and a stale-nibble timeout.

## Interface
- `TIMEOUT`, default 16: cycles allowed between accepted low and high nibble; 0 disables the timeout.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 4: nibble from link.
- `sel` in 1: 0 = low nibble (mux input `a`), 1 = high nibble (mux input `b`).
- `din_valid` in 1: `din`/`sel` valid this cycle.
- `din_ready` out 1: block accepts a nibble this cycle.
- `byte_out` out 8: `{hi, lo}` assembled byte, registered.
- `byte_valid` out 1: `byte_out` holds an unconsumed byte.
- `byte_ready` in 1: downstream consumes `byte_out`.
- `err` out 1: one-cycle error pulse.
- `err_code` out 2: cause of the latest error; holds until the next error.

## Operation
- Accept: `din_valid && din_ready`. Transfer: `byte_valid && byte_ready`.
- FSM states:
  - IDLE, expects low.
  - HAVE_LO, low stored, expects high.
- IDLE transitions:
  - Accept with `sel`=0: store `lo`, go to HAVE_LO.
  - Accept with `sel`=1: orphan high. Drop it, pulse `err`, `err_code`=01, stay in IDLE.
- HAVE_LO transitions:
  - Accept with `sel`=1: load `byte_out`={din, lo}, set `byte_valid`, go to IDLE.
  - Accept with `sel`=0: duplicate low. Replace `lo`, pulse `err`, `err_code`=10, stay in HAVE_LO, restart the timeout.
- Timeout:
  - The counter runs only in HAVE_LO. It clears on entry and on every accept.
  - When it reaches `TIMEOUT` with no accept: discard `lo`, pulse `err`, `err_code`=11, go to IDLE.
- Output register:
  - `byte_valid` clears on transfer unless a new byte loads in the same cycle. Load wins, so `byte_valid` stays 1.
- Backpressure:
  - `din_ready` = !(state==HAVE_LO && `byte_valid`).
  - It is driven from registered state only; there is no combinational path from `byte_ready`.
  - Low nibbles are always accepted in IDLE.
- Reset values:
  - State IDLE, `lo`=0, counter=0.
  - `byte_out`=0x00, `byte_valid`=0.
  - `err`=0, `err_code`=00.
  - `din_ready`=1.

## Timing
- Latency: a high nibble accepted at edge k makes `byte_valid`/`byte_out` visible after edge k (one cycle).
- Sustained throughput: one byte per 2 cycles when `byte_ready` is held high.
- Full output plus HAVE_LO: `din_ready`=0. The cycle after the transfer, `din_ready` returns to 1; there is no same-cycle bypass.
- Timeout fires exactly `TIMEOUT` cycles after the last accept in HAVE_LO with no intervening accept. An accept on the expiry cycle wins: no error, and the nibble is processed normally.
- Timeout while `din_ready`=0 (output full) is still enforced.
- `err` is asserted for exactly one cycle per event.
- Reset asserted mid-operation: all state returns to reset values asynchronously. A partially stored nibble and any pending byte are lost.

## Structure
- Shared package `demux_pkg`:
  - State enum {IDLE, HAVE_LO}.
  - Error code constants: ERR_NONE=00, ERR_ORPHAN_HI=01, ERR_DUP_LO=10, ERR_TIMEOUT=11.
- Sub-module `timeout_cnt`:
  - Inputs: `clr`, `en`. Output: `expired`.
  - Width $clog2(TIMEOUT+1).
  - Tied off when `TIMEOUT`=0.
- Top level holds the FSM, the `lo` register and the output register.

## Test plan
- Clean pair: low 0x5, then high 0xA on consecutive cycles, `byte_ready`=1 -> `byte_out`=0xA5, `byte_valid` high for 1 cycle, `err` never asserted.
- Orphan high: from reset, high 0x3 -> `err` pulse, `err_code`=01, no `byte_valid`; then low 0x1, high 0x2 -> 0x21.
- Duplicate low: low 0x4, low 0x7, high 0xC -> `err_code`=10 once, then `byte_out`=0xC7.
- Backpressure: hold `byte_ready`=0.
  - Assemble 0x21, then send low 0x9 -> accepted, `din_ready` drops to 0.
  - Release `byte_ready` -> 0x21 consumed, `din_ready`=1 the next cycle.
  - High 0xF -> 0xF9.
- Timeout with `TIMEOUT`=4:
  - Low 0x6, then idle -> `err_code`=11 exactly 4 cycles later and the state returns to IDLE.
  - Repeat with high 0x8 on the expiry cycle -> 0x86, no error.
- Async reset mid-pair: low 0x2, assert `rst_n`=0 between edges -> outputs at reset values immediately. After release, high 0xE -> `err_code`=01.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the nibble-link receive side: FSM states and error causes.
package demux_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        HAVE_LO = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_ORPHAN_HI = 2'b01;
    localparam logic [1:0] ERR_DUP_LO    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

endpackage

// File: rtl/timeout_cnt.sv
// Stale-nibble watchdog: counts enabled cycles since the last clear and flags
// the cycle whose closing edge is the TIMEOUT-th one. TIMEOUT=0 disables it.
module timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_cnt
            localparam int W = $clog2(TIMEOUT + 1);
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

            logic [W-1:0] cnt_q, cnt_d;

            // Holds at LAST; the FSM leaves HAVE_LO on the expiring edge anyway.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = en && (cnt_q == LAST);
        end else begin : g_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/demux_1_2_4b.sv
// Nibble-link receiver: pairs tagged low/high nibbles into bytes, with
// sequence checking and a stale-low timeout.
module demux_1_2_4b
    import demux_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       sel,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       err,
    output logic [1:0] err_code,
    output state_t     dbg_state_o
);

    // Handshakes: a nibble moves when din_valid && din_ready, a byte moves when
    // byte_valid && byte_ready; both sides sample on the same rising edge.
    // din_ready is built from registers only, so it never depends on byte_ready.

    state_t     state_q, state_d;
    logic [3:0] lo_q, lo_d;
    logic [7:0] byte_q, byte_d;
    logic       bvalid_q, bvalid_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;

    logic accept;
    logic xfer;
    logic expired;

    assign din_ready = !((state_q == HAVE_LO) && bvalid_q);
    assign accept    = din_valid && din_ready;
    assign xfer      = bvalid_q && byte_ready;

    timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (state_q == HAVE_LO),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        byte_d   = byte_q;
        bvalid_d = bvalid_q;
        err_d    = 1'b0;
        code_d   = code_q;

        if (xfer) begin
            bvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!sel) begin
                        lo_d    = din;
                        state_d = HAVE_LO;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_ORPHAN_HI;
                    end
                end
            end
            HAVE_LO: begin
                // An accept on the expiry cycle takes priority over the timeout.
                if (accept) begin
                    if (sel) begin
                        byte_d   = {din, lo_q};
                        bvalid_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        lo_d   = din;
                        err_d  = 1'b1;
                        code_d = ERR_DUP_LO;
                    end
                end else if (expired) begin
                    lo_d    = '0;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            byte_q   <= '0;
            bvalid_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            byte_q   <= byte_d;
            bvalid_q <= bvalid_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign byte_out    = byte_q;
    assign byte_valid  = bvalid_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_demux_1_2_4b.sv
// Bench for demux_1_2_4b: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a pairing model.
module tb_demux_1_2_4b;
    import demux_pkg::*;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] din = '0;
    logic       sel = 1'b0;
    logic       din_valid = 1'b0;
    logic       byte_ready = 1'b1;
    logic       din_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       err;
    logic [1:0] err_code;
    state_t     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_1_2_4b #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .sel         (sel),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .err         (err),
        .err_code    (err_code),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending low nibble is a 0/1-entry queue; the timeout is a cycle-stamp
    // difference; the output slot is a flag plus a byte.
    logic [3:0] m_lo_q[$];
    int         m_cyc;
    int         m_last;
    logic [7:0] m_byte;
    bit         m_valid;
    bit         m_err;
    logic [1:0] m_code;
    logic [7:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lo_q.delete();
            exp_q.delete();
            m_cyc   = 0;
            m_last  = 0;
            m_byte  = 8'h00;
            m_valid = 0;
            m_err   = 0;
            m_code  = 2'b00;
        end else begin
            bit         acc, xfer, loaded;
            logic [7:0] nb;
            m_cyc++;
            acc    = din_valid && !(m_lo_q.size() != 0 && m_valid);
            xfer   = m_valid && byte_ready;
            loaded = 0;
            nb     = 8'h00;
            m_err  = 0;
            if (acc) begin
                if (m_lo_q.size() == 0) begin
                    if (!sel) begin
                        m_lo_q.push_back(din);
                        m_last = m_cyc;
                    end else begin
                        m_err  = 1;
                        m_code = 2'b01;
                    end
                end else if (sel) begin
                    nb = {din, m_lo_q[0]};
                    m_lo_q.delete();
                    loaded = 1;
                end else begin
                    m_lo_q[0] = din;
                    m_last    = m_cyc;
                    m_err     = 1;
                    m_code    = 2'b10;
                end
            end else if (m_lo_q.size() != 0 && TIMEOUT > 0 && (m_cyc - m_last) == TIMEOUT) begin
                m_lo_q.delete();
                m_err  = 1;
                m_code = 2'b11;
            end
            if (loaded) begin
                m_byte  = nb;
                m_valid = 1;
                exp_q.push_back(nb);
            end else if (xfer) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit checking = 0;

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_byte_out", byte_out, m_byte);
            check("cyc_byte_valid", byte_valid, m_valid);
            check("cyc_err", err, m_err);
            check("cyc_err_code", err_code, m_code);
            check("cyc_din_ready", din_ready, !(m_lo_q.size() != 0 && m_valid));
            if (rst_n && byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_byte", byte_valid, 1'b0);
                end else begin
                    check("sb_byte", byte_out, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic s, input logic [3:0] d);
        din_valid = 1'b1;
        sel       = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vprob;
        #2 rst_n = 1'b0;
        #1;
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_din_ready", din_ready, 1'b1);
        checking = 1;
        #10 rst_n = 1'b1;
        tick(2);

        // clean pair
        send(1'b0, 4'h5);
        send(1'b1, 4'hA);
        check("clean_byte", byte_out, 8'hA5);
        check("clean_valid", byte_valid, 1'b1);
        check("clean_err", err, 1'b0);
        tick(1);
        check("clean_consumed", byte_valid, 1'b0);

        // orphan high
        send(1'b1, 4'h3);
        check("orphan_err", err, 1'b1);
        check("orphan_code", err_code, 2'b01);
        check("orphan_no_byte", byte_valid, 1'b0);
        tick(1);
        check("orphan_pulse_1cyc", err, 1'b0);
        send(1'b0, 4'h1);
        send(1'b1, 4'h2);
        check("orphan_then_byte", byte_out, 8'h21);

        // duplicate low
        send(1'b0, 4'h4);
        send(1'b0, 4'h7);
        check("dup_err", err, 1'b1);
        check("dup_code", err_code, 2'b10);
        send(1'b1, 4'hC);
        check("dup_byte", byte_out, 8'hC7);
        check("dup_err_cleared", err, 1'b0);
        check("dup_code_held", err_code, 2'b10);
        tick(1);

        // backpressure
        byte_ready = 1'b0;
        send(1'b0, 4'h1);
        send(1'b1, 4'h2);
        check("bp_byte", byte_out, 8'h21);
        send(1'b0, 4'h9);
        check("bp_ready_low", din_ready, 1'b0);
        check("bp_still_valid", byte_valid, 1'b1);
        byte_ready = 1'b1;
        tick(1);
        check("bp_consumed", byte_valid, 1'b0);
        check("bp_ready_back", din_ready, 1'b1);
        send(1'b1, 4'hF);
        check("bp_byte2", byte_out, 8'hF9);
        tick(1);

        // timeout
        send(1'b0, 4'h6);
        tick(TIMEOUT - 1);
        check("to_no_err_yet", err, 1'b0);
        check("to_state_have_lo", dbg_state, HAVE_LO);
        tick(1);
        check("to_err", err, 1'b1);
        check("to_code", err_code, 2'b11);
        check("to_state_idle", dbg_state, IDLE);
        tick(1);
        check("to_pulse_1cyc", err, 1'b0);

        // accept on the expiry cycle wins
        send(1'b0, 4'h6);
        tick(TIMEOUT - 1);
        send(1'b1, 4'h8);
        check("to_race_byte", byte_out, 8'h86);
        check("to_race_no_err", err, 1'b0);
        tick(1);

        // timeout while output is full
        byte_ready = 1'b0;
        send(1'b0, 4'h1);
        send(1'b1, 4'h2);
        send(1'b0, 4'h3);
        tick(TIMEOUT - 1);
        check("tofull_ready_low", din_ready, 1'b0);
        tick(1);
        check("tofull_err", err, 1'b1);
        check("tofull_code", err_code, 2'b11);
        check("tofull_ready_back", din_ready, 1'b1);
        check("tofull_byte_kept", byte_out, 8'h21);
        byte_ready = 1'b1;
        tick(2);

        // async reset mid-pair with a pending byte
        byte_ready = 1'b0;
        send(1'b0, 4'h1);
        send(1'b1, 4'h2);
        send(1'b0, 4'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_byte_valid", byte_valid, 1'b0);
        check("arst_byte_out", byte_out, 8'h00);
        check("arst_din_ready", din_ready, 1'b1);
        check("arst_err_code", err_code, 2'b00);
        check("arst_state", dbg_state, IDLE);
        #3 rst_n = 1'b1;
        tick(1);
        byte_ready = 1'b1;
        send(1'b1, 4'hE);
        check("arst_orphan_err", err, 1'b1);
        check("arst_orphan_code", err_code, 2'b01);
        tick(1);

        // randomized traffic
        vprob = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                vprob = (i % 1500 == 0) ? 12 : ((i % 1000 == 0) ? 90 : 55);
            end
            din_valid  = ($urandom_range(0, 99) < vprob);
            sel        = $urandom_range(0, 1);
            din        = 4'($urandom_range(0, 15));
            byte_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
